// File: rtl/modulo_mef_contador_parametrizado_pkg.sv
// Shared FSM encodings for the buffered down-counter controller.
// Encodings are fixed because the state port is read by debug tooling.
package modulo_mef_contador_parametrizado_pkg;

  localparam int ST_W = 2;

  typedef logic [ST_W-1:0] st_t;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'b00;
  localparam logic [ST_W-1:0] ST_LOAD  = 2'b01;
  localparam logic [ST_W-1:0] ST_COUNT = 2'b10;
  localparam logic [ST_W-1:0] ST_DONE  = 2'b11;

  function automatic logic st_is_busy(input st_t st);
    return st != ST_IDLE;
  endfunction

endpackage

// File: rtl/modulo_mef_contador_parametrizado_contador.sv
// WIDTH-bit loadable down-counter; priority clr > load > dec, updates on the next edge.
// Decrement is ignored at zero so the value can never wrap.
module modulo_contador_param
  import modulo_mef_contador_parametrizado_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             last
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = d;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q    = cnt_q;
  assign last = (cnt_q == ONE);

endmodule

// File: rtl/modulo_mef_contador_parametrizado.sv
// Pops one buffer entry per request, counts it down to zero and pulses done; N+2 cycles for value N.
// enable low freezes state and count and forces every strobe low; dropping load_req aborts a count.
module modulo_mef_contador_parametrizado
  import modulo_mef_contador_parametrizado_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int AUTO_RELOAD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load_req,
  input  logic             buf_empty,
  input  logic [WIDTH-1:0] buf_data,
  output logic             buf_pop,
  output logic             count_load,
  output logic             count_en,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             busy,
  output logic [ST_W-1:0]  state
);

  st_t state_d;
  st_t state_q;

  logic in_load;
  logic in_count;
  logic in_done;
  logic abort;
  logic cnt_last;

  // Strobes are state decodes gated by enable only, so no request/buffer input reaches an output.
  assign in_load  = enable && (state_q == ST_LOAD);
  assign in_count = enable && (state_q == ST_COUNT);
  assign in_done  = enable && (state_q == ST_DONE);
  assign abort    = in_count && !load_req;

  always_comb begin
    state_d = state_q;
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (load_req && !buf_empty) begin
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          state_d = (buf_data == '0) ? ST_DONE : ST_COUNT;
        end
        ST_COUNT: begin
          if (!load_req) begin
            state_d = ST_IDLE;
          end else if (cnt_last) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if ((AUTO_RELOAD != 0) && load_req && !buf_empty) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  modulo_contador_param #(
    .WIDTH (WIDTH)
  ) u_contador (
    .clk  (clk),
    .rst  (rst),
    .load (in_load),
    .dec  (in_count),
    .clr  (abort),
    .d    (buf_data),
    .q    (count),
    .last (cnt_last)
  );

  assign buf_pop    = in_load;
  assign count_load = in_load;
  assign count_en   = in_count;
  assign done       = in_done;
  assign busy       = st_is_busy(state_q);
  assign state      = state_q;

endmodule

// File: tb/tb_modulo_mef_contador_parametrizado.sv
module tb_modulo_mef_contador_parametrizado;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       load_req;
  logic       buf_empty;
  logic [7:0] buf_data;

  logic       buf_pop0, count_load0, count_en0, done0, busy0;
  logic [7:0] count0;
  logic [1:0] state0;
  logic       buf_pop1, count_load1, count_en1, done1, busy1;
  logic [7:0] count1;
  logic [1:0] state1;

  int checks = 0;
  int errors = 0;

  modulo_mef_contador_parametrizado #(.WIDTH(8), .AUTO_RELOAD(0)) dut0 (
    .clk(clk), .rst(rst_n), .enable(enable), .load_req(load_req),
    .buf_empty(buf_empty), .buf_data(buf_data), .buf_pop(buf_pop0),
    .count_load(count_load0), .count_en(count_en0), .count(count0),
    .done(done0), .busy(busy0), .state(state0)
  );

  modulo_mef_contador_parametrizado #(.WIDTH(8), .AUTO_RELOAD(1)) dut1 (
    .clk(clk), .rst(rst_n), .enable(enable), .load_req(load_req),
    .buf_empty(buf_empty), .buf_data(buf_data), .buf_pop(buf_pop1),
    .count_load(count_load1), .count_en(count_en1), .count(count1),
    .done(done1), .busy(busy1), .state(state1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Table vectors: inputs for one cycle and the outputs expected during that cycle.
  typedef struct packed {
    logic       en;
    logic       req;
    logic       emp;
    logic [7:0] data;
    logic [1:0] st;
    logic [7:0] cnt;
    logic       pop;
    logic       cen;
    logic       dn;
    logic       bsy;
  } vec_t;

  // Reference model: a request becomes a job; its age (enabled cycles since acceptance) fixes the outputs.
  typedef struct {
    bit active;
    int age;
    int n;
  } job_t;

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] cnt;
    logic       pop;
    logic       cen;
    logic       dn;
    logic       bsy;
  } obs_t;

  function automatic vec_t v(bit en, bit req, bit emp, int d, int st, int cnt,
                             bit pop, bit cen, bit dn, bit bsy);
    vec_t r;
    r.en = en; r.req = req; r.emp = emp; r.data = 8'(d);
    r.st = 2'(st); r.cnt = 8'(cnt);
    r.pop = pop; r.cen = cen; r.dn = dn; r.bsy = bsy;
    return r;
  endfunction

  function automatic obs_t predict(job_t j, bit en);
    obs_t o;
    o = '0;
    if (j.active) begin
      o.bsy = 1'b1;
      if (j.age == 1) begin
        o.st  = 2'd1;
        o.pop = en;
      end else if (j.age <= j.n + 1) begin
        o.st  = 2'd2;
        o.cnt = 8'(j.n + 2 - j.age);
        o.cen = en;
      end else begin
        o.st = 2'd3;
        o.dn = en;
      end
    end
    return o;
  endfunction

  function automatic job_t advance(job_t j, bit en, bit req, bit emp, int data, bit ar);
    job_t r;
    r = j;
    if (!en) return r;
    if (!j.active) begin
      if (req && !emp) begin
        r.active = 1'b1;
        r.age    = 1;
      end
    end else if (j.age == 1) begin
      r.n   = data;
      r.age = 2;
    end else if (j.age <= j.n + 1) begin
      if (!req) r.active = 1'b0;
      else      r.age    = j.age + 1;
    end else begin
      if (ar && req && !emp) r.age    = 1;
      else                   r.active = 1'b0;
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b0;
    load_req  = 1'b0;
    buf_empty = 1'b1;
    buf_data  = 8'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t tbl[$];
    job_t m0;
    job_t m1;
    obs_t e0;
    obs_t e1;
    int   q[$];
    bit   pend;
    int   pops;
    int   dones;
    bit   direct;
    bit   seen;
    logic [1:0] prev;

    //            en req emp data | st cnt pop cen dn bsy
    tbl.push_back(v(1, 1, 0, 3,   0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 3,   1, 0, 1, 0, 0, 1));
    tbl.push_back(v(1, 1, 1, 0,   2, 3, 0, 1, 0, 1));
    tbl.push_back(v(1, 1, 1, 0,   2, 2, 0, 1, 0, 1));
    tbl.push_back(v(1, 1, 1, 0,   2, 1, 0, 1, 0, 1));
    tbl.push_back(v(1, 1, 1, 0,   3, 0, 0, 0, 1, 1));
    tbl.push_back(v(1, 0, 1, 0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,   1, 0, 1, 0, 0, 1));
    tbl.push_back(v(1, 0, 1, 0,   3, 0, 0, 0, 1, 1));
    tbl.push_back(v(1, 0, 1, 0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 4,   0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 4,   1, 0, 1, 0, 0, 1));
    tbl.push_back(v(1, 1, 1, 0,   2, 4, 0, 1, 0, 1));
    tbl.push_back(v(1, 1, 1, 0,   2, 3, 0, 1, 0, 1));
    tbl.push_back(v(0, 1, 1, 0,   2, 2, 0, 0, 0, 1));
    tbl.push_back(v(0, 1, 1, 0,   2, 2, 0, 0, 0, 1));
    tbl.push_back(v(1, 1, 1, 0,   2, 2, 0, 1, 0, 1));
    tbl.push_back(v(1, 1, 1, 0,   2, 1, 0, 1, 0, 1));
    tbl.push_back(v(1, 1, 1, 0,   3, 0, 0, 0, 1, 1));
    tbl.push_back(v(1, 0, 1, 0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 5,   0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 5,   0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 5,   0, 0, 0, 0, 0, 0));

    // Reset state, observed before any clock edge.
    rst_n = 1'b0; enable = 1'b1; load_req = 1'b1; buf_empty = 1'b0; buf_data = 8'd3;
    #2;
    chk("reset_state", int'(state0), 0);
    chk("reset_count", int'(count0), 0);
    chk("reset_busy", int'(busy0), 0);
    chk("reset_strobes", int'({buf_pop0, count_load0, count_en0, done0}), 0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      enable = tbl[i].en; load_req = tbl[i].req;
      buf_empty = tbl[i].emp; buf_data = tbl[i].data;
      #1;
      chk($sformatf("tbl%0d_state", i), int'(state0), int'(tbl[i].st));
      chk($sformatf("tbl%0d_count", i), int'(count0), int'(tbl[i].cnt));
      chk($sformatf("tbl%0d_pop", i), int'(buf_pop0), int'(tbl[i].pop));
      chk($sformatf("tbl%0d_load", i), int'(count_load0), int'(tbl[i].pop));
      chk($sformatf("tbl%0d_cen", i), int'(count_en0), int'(tbl[i].cen));
      chk($sformatf("tbl%0d_done", i), int'(done0), int'(tbl[i].dn));
      chk($sformatf("tbl%0d_busy", i), int'(busy0), int'(tbl[i].bsy));
    end

    // Abort: drop load_req while count shows 5.
    do_reset();
    @(negedge clk);
    enable = 1'b1; load_req = 1'b1; buf_empty = 1'b0; buf_data = 8'd7;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      buf_empty = 1'b1;
      #1;
      if (count0 == 8'd5 && state0 == 2'd2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("abort_reach5", int'(seen), 1);
    load_req = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_state", int'(state0), 0);
    chk("abort_count", int'(count0), 0);
    chk("abort_busy", int'(busy0), 0);
    seen = done0;
    repeat (3) begin
      @(negedge clk);
      #1;
      seen = seen | done0;
    end
    chk("abort_no_done", int'(seen), 0);

    // Auto-reload on dut1: buffer holds 2 then 1.
    do_reset();
    q = '{2, 1};
    pend = 1'b0; pops = 0; dones = 0; direct = 1'b0; prev = 2'd0;
    enable = 1'b1; load_req = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (pend) begin
        void'(q.pop_front());
        pend = 1'b0;
      end
      buf_empty = (q.size() == 0);
      if (q.size() != 0) buf_data = 8'(q[0]);
      else               buf_data = 8'd0;
      #1;
      if (prev == 2'd3 && dones == 1 && pops == 1) direct = (state1 == 2'd1);
      if (buf_pop1) begin
        pops++;
        pend = 1'b1;
      end
      if (done1) dones++;
      prev = state1;
    end
    chk("ar_pops", pops, 2);
    chk("ar_dones", dones, 2);
    chk("ar_direct_load", int'(direct), 1);
    chk("ar_final_idle", int'(state1), 0);

    // Asynchronous reset between edges while count shows 4.
    do_reset();
    @(negedge clk);
    enable = 1'b1; load_req = 1'b1; buf_empty = 1'b0; buf_data = 8'd6;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      buf_empty = 1'b1;
      #1;
      if (count0 == 8'd4 && state0 == 2'd2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("arst_reach4", int'(seen), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_state", int'(state0), 0);
    chk("arst_count", int'(count0), 0);
    chk("arst_busy", int'(busy0), 0);
    chk("arst_strobes", int'({buf_pop0, count_load0, count_en0, done0}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      seen = seen | buf_pop0 | (state0 != 2'd0);
    end
    chk("arst_no_pop_after", int'(seen), 0);

    // Random stimulus against the job-timeline model, both AUTO_RELOAD settings.
    do_reset();
    m0 = '{active: 1'b0, age: 0, n: 0};
    m1 = '{active: 1'b0, age: 0, n: 0};
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      enable    = ($urandom_range(0, 9) != 0);
      load_req  = ($urandom_range(0, 15) != 0);
      buf_empty = ($urandom_range(0, 3) == 0);
      buf_data  = 8'($urandom_range(0, 9));
      #1;
      e0 = predict(m0, enable);
      e1 = predict(m1, enable);
      chk($sformatf("rnd%0d_ar0", c),
          int'({state0, count0, buf_pop0, count_en0, done0, busy0}), int'(e0));
      chk($sformatf("rnd%0d_ar1", c),
          int'({state1, count1, buf_pop1, count_en1, done1, busy1}), int'(e1));
      m0 = advance(m0, enable, load_req, buf_empty, int'(buf_data), 1'b0);
      m1 = advance(m1, enable, load_req, buf_empty, int'(buf_data), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
